// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// DM has priority, and a starvation counter makes sure fetch is eventually served.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_spurious
);

  localparam logic IDLE   = 1'b0;
  localparam logic BUSY   = 1'b1;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          state;
  logic          owner;
  logic          kill;
  logic [CW-1:0] starve_cnt;

  logic sel_if;
  logic sel_dm;
  logic fire;
  logic rsp;

  // Requester selection: data first unless fetch has waited too long
  always_comb begin
    sel_if = if_req & (~dm_req | (starve_cnt == LIMIT));
    sel_dm = dm_req & ~sel_if;
  end

  // Memory request mux and grant/response decode
  always_comb begin
    mem_req   = ~reset & (state == IDLE) & (if_req | dm_req);
    mem_we    = sel_dm & dm_we;
    mem_be    = sel_dm ? dm_be : 4'hF;
    mem_addr  = sel_dm ? dm_addr : if_addr;
    mem_wdata = sel_dm ? dm_wdata : 32'h0;
    fire      = mem_req & mem_ready;
    if_gnt    = fire & sel_if;
    dm_gnt    = fire & sel_dm;
    rsp       = ~reset & (state == BUSY) & mem_rvalid;
    if_rvalid = rsp & (owner == OWN_IF) & ~kill & ~if_kill;
    dm_rvalid = rsp & (owner == OWN_DM);
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
  end

  // Transaction FSM: owner, kill tracking and spurious-response flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      kill         <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_rvalid)
            err_spurious <= 1'b1;
          if (fire) begin
            state <= BUSY;
            owner <= sel_dm;
            kill  <= sel_if & if_kill;
          end
        end
        BUSY: begin
          if (mem_rvalid) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else if (if_kill && owner == OWN_IF) begin
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts data grants taken while fetch is waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (dm_gnt && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants tolerated while fetch waits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports if_req in 1, if_addr in 32: fetch-stage read request and byte address.
REQ-005 SHALL have port if_kill  input  1  fetch flush (branch/jump redirect), cancels the in-flight fetch response.
REQ-006 SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch grant, response strobe, instruction word.
REQ-007 SHALL have ports dm_req in 1, dm_we in 1, dm_be in 4, dm_addr in 32, dm_wdata in 32: memory-stage load/store request.
REQ-008 SHALL have ports dm_gnt out 1, dm_rvalid out 1, dm_rdata out 32: data grant, response/ack strobe, load data.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out 32, mem_wdata out 32: shared single-port memory request.
REQ-010 SHALL have ports mem_ready in 1, mem_rvalid in 1, mem_rdata in 32: memory accept, response strobe, read data.
REQ-011 SHALL have port err_spurious  output  1  sticky flag, mem_rvalid received with nothing outstanding.

Function
REQ-012 SHALL implement FSM states IDLE and BUSY, plus owner register (IF/DM), kill register, and starvation counter.
REQ-013 SHALL in IDLE drive mem_req = if_req | dm_req, with mem_we/be/addr/wdata taken from the selected requester; mem_we=0, mem_be=4'hF for a fetch.
REQ-014 SHALL select DM over IF when both request, unless starvation counter == STARVE_LIMIT, in which case IF is selected.
REQ-015 SHALL assert the selected requester's gnt combinationally in the cycle IDLE && mem_req && mem_ready, and never assert both gnts in one cycle.
REQ-016 SHALL on grant move to BUSY next cycle, latching owner; mem_req SHALL be 0 throughout BUSY.
REQ-017 SHALL in BUSY on mem_rvalid pulse the owner's rvalid for that cycle with rdata = mem_rdata, then return to IDLE; stores complete the same way (dm_rvalid as write ack).
REQ-018 SHALL permit a new grant no earlier than the cycle after the response (minimum 2 cycles per transaction).
REQ-019 SHALL drive non-owner rvalid = 0, and if_rdata/dm_rdata = mem_rdata unconditionally (valid only with rvalid).
REQ-020 SHALL set kill register when if_kill is high while BUSY with owner IF, or when if_kill coincides with an IF grant; killed response SHALL be consumed with if_rvalid = 0; kill register clears on return to IDLE.
REQ-021 SHALL ignore if_kill when no fetch is in flight.
REQ-022 SHALL increment starvation counter (saturating at STARVE_LIMIT) on each DM grant while if_req = 1; clear it on IF grant or any cycle with if_req = 0.
REQ-023 SHALL set err_spurious on mem_rvalid in IDLE, with no rvalid forwarded and no state change.
REQ-024 SHALL require requesters to hold req and fields stable until gnt; arbiter holds no request buffer.
REQ-025 SHALL tolerate mem_ready low indefinitely in IDLE, re-evaluating selection each cycle (a newly arriving DM may overtake a waiting IF).

Reset
REQ-026 SHALL on reset go to IDLE, clear owner, kill, counter, err_spurious; all gnt/rvalid outputs 0 during reset cycle.
REQ-027 SHALL on reset mid-BUSY abandon the outstanding transaction; a later mem_rvalid is treated per REQ-023.

Verification
REQ-028 Single fetch: if_req=1, if_addr=0x100, mem_ready=1 at cycle 0, mem_rvalid with 0x00500093 at cycle 2 -> if_gnt at 0, if_rvalid=1/if_rdata=0x00500093 at 2.
REQ-029 Contention: if_req and dm_req (load 0x2000) both high, mem_ready=1 -> dm_gnt first, if_gnt in cycle after DM response.
REQ-030 Starvation: if_req held, dm_req held for 6 back-to-back loads, STARVE_LIMIT=4 -> 4 DM grants, then IF grant, then DM resumes.
REQ-031 Kill: fetch granted, if_kill pulsed in BUSY, mem_rvalid arrives -> if_rvalid stays 0, FSM IDLE next cycle, next fetch served normally.
REQ-032 Store ack + backpressure: dm_we=1, dm_be=4'b0011, mem_ready=0 for 3 cycles -> no gnt for 3 cycles, mem_we=1/mem_be=0011 held, dm_gnt on 4th, dm_rvalid on response.
REQ-033 Reset mid-BUSY then mem_rvalid -> no rvalid output, err_spurious=1 until next reset.
